// File: rtl/lane_pack.sv
// lane_pack: gathers a stream of narrow lane beats into one wide word.
// Lane 0 arrives first, and lane k lands in bits [k*LANE_WIDTH +: LANE_WIDTH].
// Both sides use a valid/ready handshake. The block sustains one word every
// NUM_LANES beats with no bubble.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   i_flush       synchronous discard of the partial or held word
//   i_lane_data   lane beat payload (LANE_WIDTH bits)
//   i_lane_valid  lane beat valid
//   o_lane_ready  lane beat accepted when valid && ready
//   o_data_out    packed word (NUM_LANES*LANE_WIDTH bits)
//   o_data_valid  packed word valid
//   i_data_ready  downstream accepts the word when valid && ready
//   o_lane_idx    index of the next lane to be filled
module lane_pack #(
    parameter int NUM_LANES  = 2,
    parameter int LANE_WIDTH = 1,
    parameter int IDX_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_flush,
    input  logic [LANE_WIDTH-1:0]           i_lane_data,
    input  logic                            i_lane_valid,
    output logic                            o_lane_ready,
    output logic [NUM_LANES*LANE_WIDTH-1:0] o_data_out,
    output logic                            o_data_valid,
    input  logic                            i_data_ready,
    output logic [IDX_W-1:0]                o_lane_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                                  state_reg, state_next;
    logic [IDX_W-1:0]                        idx_reg, idx_next;
    logic [NUM_LANES-1:0][LANE_WIDTH-1:0]    data_reg, data_next;
    logic [NUM_LANES-1:0]                    lane_we;
    logic                                    lane_ready;
    logic                                    accept;
    logic                                    last_lane;

    // A held word blocks new beats unless downstream takes it this cycle.
    // In that case the word leaves on the same edge that slice 0 is
    // rewritten, so no bubble is inserted.
    assign lane_ready = !rst && ((state_reg == FILL) || i_data_ready);
    assign accept     = i_lane_valid && lane_ready && !i_flush;
    assign last_lane  = (idx_reg == LAST_IDX);

    // Each lane slice has its own write enable. Only the slice addressed
    // by the index counter can change on a given edge.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign lane_we[gi]   = accept && (idx_reg == IDX_W'(gi));
            assign data_next[gi] = lane_we[gi] ? i_lane_data : data_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        if (i_flush) begin
            // A flush beats any lane accept. A handshake downstream still
            // completes because the valid/ready pair was visible this cycle.
            state_next = FILL;
            idx_next   = '0;
        end else begin
            if ((state_reg == HOLD) && i_data_ready) begin
                state_next = FILL;
            end
            if (accept) begin
                if (last_lane) begin
                    // With NUM_LANES == 1, this keeps HOLD on a handshake.
                    idx_next   = '0;
                    state_next = HOLD;
                end else begin
                    idx_next = idx_reg + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= FILL;
            idx_reg   <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            data_reg  <= data_next;
        end
    end

    assign o_lane_ready = lane_ready;
    assign o_data_out   = data_reg;
    assign o_data_valid = (state_reg == HOLD);
    assign o_lane_idx   = idx_reg;

endmodule

// File: tb/tb_lane_pack.sv
// Testbench for lane_pack. It drives two instances: 2 lanes x 1 bit (index 0)
// and 4 lanes x 8 bits (index 1). A reference model tracks the collected
// beats and the held word, and it predicts ready, valid, index and word.
module tb_lane_pack;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       lv [2];
    logic [7:0] ld [2];
    logic       dr [2];
    logic       fl [2];

    logic       a_ready, a_valid, a_idx;
    logic [1:0] a_data;
    logic        b_ready, b_valid;
    logic [1:0]  b_idx;
    logic [31:0] b_data;

    lane_pack #(.NUM_LANES(2), .LANE_WIDTH(1)) dut_a (
        .clk(clk), .rst(rst), .i_flush(fl[0]),
        .i_lane_data(ld[0][0:0]), .i_lane_valid(lv[0]), .o_lane_ready(a_ready),
        .o_data_out(a_data), .o_data_valid(a_valid), .i_data_ready(dr[0]),
        .o_lane_idx(a_idx)
    );

    lane_pack #(.NUM_LANES(4), .LANE_WIDTH(8)) dut_b (
        .clk(clk), .rst(rst), .i_flush(fl[1]),
        .i_lane_data(ld[1]), .i_lane_valid(lv[1]), .o_lane_ready(b_ready),
        .o_data_out(b_data), .o_data_valid(b_valid), .i_data_ready(dr[1]),
        .o_lane_idx(b_idx)
    );

    logic [31:0] od [2];
    logic        ov [2];
    logic        orr [2];
    logic [31:0] oi [2];
    assign od[0] = 32'(a_data);
    assign od[1] = b_data;
    assign ov[0] = a_valid;
    assign ov[1] = b_valid;
    assign orr[0] = a_ready;
    assign orr[1] = b_ready;
    assign oi[0] = 32'(a_idx);
    assign oi[1] = 32'(b_idx);

    // Reference model: collected beats of the current word, plus the word
    // that is waiting for downstream.
    int          nl [2] = '{2, 4};
    int          lw [2] = '{1, 8};
    logic [7:0]  part [2][4];
    int          pcnt [2];
    logic        held [2];
    logic [31:0] held_word [2];

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            pcnt[d] = 0;
            held[d] = 1'b0;
            held_word[d] = '0;
        end
    endtask

    task automatic set_in(input int d, input logic v, input logic [7:0] data,
                          input logic r, input logic f);
        lv[d] = v;
        ld[d] = data;
        dr[d] = r;
        fl[d] = f;
    endtask

    // Compare the DUT with the model, then apply this cycle's inputs to the
    // model.
    task automatic model_step(input int d);
        logic rdy;
        logic [7:0] mask;
        rdy  = !held[d] || dr[d];
        mask = (lw[d] >= 8) ? 8'hFF : 8'((1 << lw[d]) - 1);
        check($sformatf("ready%0d", d), 32'(orr[d]), 32'(rdy));
        check($sformatf("valid%0d", d), 32'(ov[d]), 32'(held[d]));
        check($sformatf("idx%0d", d), oi[d], 32'(pcnt[d]));
        if (held[d]) check($sformatf("word%0d", d), od[d], held_word[d]);
        if (fl[d]) begin
            held[d] = 1'b0;
            pcnt[d] = 0;
        end else begin
            if (held[d] && dr[d]) held[d] = 1'b0;
            if (lv[d] && rdy) begin
                part[d][pcnt[d]] = ld[d] & mask;
                pcnt[d]++;
                if (pcnt[d] == nl[d]) begin
                    held_word[d] = '0;
                    for (int k = 0; k < nl[d]; k++)
                        held_word[d] = held_word[d] | (32'(part[d][k]) << (k * lw[d]));
                    held[d] = 1'b1;
                    pcnt[d] = 0;
                end
            end
        end
    endtask

    // Called just after a rising edge. It checks at the falling edge and
    // returns just after the next rising edge.
    task automatic cycle();
        @(negedge clk);
        for (int d = 0; d < 2; d++) model_step(d);
        @(posedge clk);
        #1;
    endtask

    int vcount;

    initial begin
        for (int d = 0; d < 2; d++) set_in(d, 1'b0, 8'h00, 1'b1, 1'b0);
        model_reset();

        // Reset state while rst is held
        #2;
        check("rst_a_valid", 32'(a_valid), 32'd0);
        check("rst_a_data", 32'(a_data), 32'd0);
        check("rst_b_data", b_data, 32'd0);
        check("rst_b_idx", 32'(b_idx), 32'd0);
        check("rst_a_ready", 32'(a_ready), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_a_ready", 32'(a_ready), 32'd1);
        check("post_rst_b_ready", 32'(b_ready), 32'd1);

        // 2x1: beats 1,0 give 2'b01
        set_in(0, 1'b1, 8'h01, 1'b1, 1'b0);
        cycle();
        check("a_idx_after_b0", 32'(a_idx), 32'd1);
        set_in(0, 1'b1, 8'h00, 1'b1, 1'b0);
        cycle();
        check("a_valid_word", 32'(a_valid), 32'd1);
        check("a_word_01", 32'(a_data), 32'h1);
        check("a_idx_wrap", 32'(a_idx), 32'd0);
        set_in(0, 1'b0, 8'h00, 1'b1, 1'b0);
        cycle();
        check("a_valid_one_cycle", 32'(a_valid), 32'd0);

        // 4x8: beats 11..44 give 44332211
        for (int k = 1; k <= 4; k++) begin
            set_in(1, 1'b1, 8'(k * 8'h11), 1'b1, 1'b0);
            cycle();
        end
        check("b_word_valid", 32'(b_valid), 32'd1);
        check("b_word", b_data, 32'h44332211);
        set_in(1, 1'b0, 8'h00, 1'b1, 1'b0);
        cycle();
        check("b_valid_one_cycle", 32'(b_valid), 32'd0);

        // Backpressure on 4x8
        for (int k = 1; k <= 4; k++) begin
            set_in(1, 1'b1, 8'(k), 1'b0, 1'b0);
            cycle();
        end
        for (int k = 0; k < 5; k++) begin
            set_in(1, 1'b1, 8'hAA, 1'b0, 1'b0);
            #1;
            check("bp_ready_low", 32'(b_ready), 32'd0);
            cycle();
            check("bp_data_stable", b_data, 32'h04030201);
            check("bp_valid_stable", 32'(b_valid), 32'd1);
        end
        set_in(1, 1'b1, 8'hAA, 1'b1, 1'b0);
        #1;
        check("bp_ready_release", 32'(b_ready), 32'd1);
        cycle();
        check("bp_consumed", 32'(b_valid), 32'd0);
        check("bp_idx_1", 32'(b_idx), 32'd1);
        set_in(1, 1'b0, 8'h00, 1'b1, 1'b1);
        cycle();
        set_in(1, 1'b0, 8'h00, 1'b1, 1'b0);

        // Continuous stream of 8 beats on 2x1
        vcount = 0;
        for (int k = 0; k < 9; k++) begin
            if (k < 8) set_in(0, 1'b1, 8'($urandom_range(0, 1)), 1'b1, 1'b0);
            else       set_in(0, 1'b0, 8'h00, 1'b1, 1'b0);
            cycle();
            if (a_valid) vcount++;
        end
        check("stream_word_count", 32'(vcount), 32'd4);

        // Flush a partial word, then a held word
        set_in(0, 1'b1, 8'h01, 1'b1, 1'b0);
        cycle();
        set_in(0, 1'b0, 8'h00, 1'b1, 1'b1);
        cycle();
        check("flush_idx", 32'(a_idx), 32'd0);
        for (int k = 0; k < 2; k++) begin
            set_in(0, 1'b1, 8'h01, 1'b0, 1'b0);
            cycle();
        end
        check("after_flush_word", 32'(a_data), 32'h3);
        check("after_flush_valid", 32'(a_valid), 32'd1);
        set_in(0, 1'b0, 8'h00, 1'b0, 1'b1);
        cycle();
        check("flush_hold_valid", 32'(a_valid), 32'd0);
        set_in(0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset with 2x1 holding and 4x8 partway through a word
        for (int k = 0; k < 2; k++) begin
            set_in(0, 1'b1, 8'h01, 1'b0, 1'b0);
            set_in(1, 1'b1, 8'h5A, 1'b1, 1'b0);
            cycle();
        end
        set_in(0, 1'b0, 8'h00, 1'b0, 1'b0);
        set_in(1, 1'b0, 8'h00, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_a_valid", 32'(a_valid), 32'd0);
        check("arst_a_data", 32'(a_data), 32'd0);
        check("arst_b_idx", 32'(b_idx), 32'd0);
        check("arst_b_data", b_data, 32'd0);
        check("arst_b_ready", 32'(b_ready), 32'd0);
        model_reset();
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        set_in(0, 1'b1, 8'h00, 1'b1, 1'b0);
        cycle();
        set_in(0, 1'b1, 8'h01, 1'b1, 1'b0);
        cycle();
        check("arst_word_10", 32'(a_data), 32'h2);
        set_in(0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic on both instances
        for (int c = 0; c < 800; c++) begin
            for (int d = 0; d < 2; d++)
                set_in(d, $urandom_range(0, 3) != 0, 8'($urandom),
                       $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
